// File: rtl/uart_pkg.sv
// Shared UART definitions used by the packet transmitter and the receiver.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        UART_START_BIT = 1'b0;
    localparam logic        UART_STOP_BIT  = 1'b1;
    localparam logic        UART_IDLE      = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    // Payload width for a packet of the given number of bytes.
    function automatic int unsigned storage_max(input int unsigned bytes);
        return UART_DATA_BITS * bytes;
    endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: wraps every CLK_DIV cycles and flags the last cycle of
// each period. A synchronous clear holds it at zero so a frame always starts
// on a fresh period.
module baud_tick #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: advance, wrapping at the end of the period or on clear.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Period counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_packet_tx.sv
// Packet transmitter: sends a STORAGE_MAX-bit word as BYTES back-to-back UART
// frames, most significant byte first, data bits MSB first.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data).
module uart_packet_tx
    import uart_pkg::*;
#(
    parameter  int unsigned CLK_DIV     = 16,
    parameter  int unsigned BYTES       = 2,
    localparam int unsigned STORAGE_MAX = storage_max(BYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [STORAGE_MAX-1:0] storage,
    output logic                   uart_data,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned       BYTE_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
    localparam logic [2:0]        FIRST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t               state_q, state_d;
    logic [STORAGE_MAX-1:0]  shift_q, shift_d;
    logic [2:0]              bit_q, bit_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    logic                    line_q, line_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic tick;
    logic baud_clr;

    // The bit period restarts from zero whenever the line is idle.
    assign baud_clr = (state_q == TX_IDLE);

    baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (baud_clr),
        .tick_o  (tick)
    );

    // Next-state logic; outputs are decoded from the next state so that the
    // line, busy and done all come straight from flops.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d = TX_START;
                    shift_d = storage;
                    byte_d  = '0;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_d = TX_DATA;
                    bit_d   = FIRST_BIT;
`ifdef UART_TX_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            TX_DATA: begin
                if (tick) begin
                    shift_d = {shift_q[STORAGE_MAX-2:0], 1'b0};
                    bit_d   = bit_q - 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_q ^ shift_q[STORAGE_MAX-1];
`endif
                    if (bit_q == '0) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = TX_START;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        case (state_d)
            TX_START:  line_d = UART_START_BIT;
            TX_DATA:   line_d = shift_d[STORAGE_MAX-1];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: line_d = parity_d;
`endif
            TX_STOP:   line_d = UART_STOP_BIT;
            default:   line_d = UART_IDLE;
        endcase

        busy_d = (state_d != TX_IDLE);
    end

    // State, datapath and output registers; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            line_q  <= UART_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign uart_data = line_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Self-checking bench for uart_packet_tx: two instances (CLK_DIV=4/BYTES=2 and
// CLK_DIV=2/BYTES=1). Expected line bits are queued per cycle when a packet is
// launched and compared on the falling clock edge while busy is high.
module tb_uart_packet_tx;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned LEN_A = 2 * FRAME_BITS * 4;
    localparam int unsigned LEN_B = 1 * FRAME_BITS * 2;

    logic        clk = 1'b0;
    logic        a_rst, a_start, a_line, a_busy, a_done;
    logic [15:0] a_storage;
    logic        b_rst, b_start, b_line, b_busy, b_done;
    logic [7:0]  b_storage;

    always #5 clk = ~clk;

    uart_packet_tx #(.CLK_DIV(4), .BYTES(2)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .storage(a_storage),
        .uart_data(a_line), .busy(a_busy), .done(a_done)
    );

    uart_packet_tx #(.CLK_DIV(2), .BYTES(1)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .storage(b_storage),
        .uart_data(b_line), .busy(b_busy), .done(b_done)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit          qa[$];
    bit          qb[$];
    bit          mon_en = 1'b0;
    int unsigned busy_run[2];
    int unsigned idle_run[2];
    int unsigned last_gap[2];
    int unsigned done_cnt[2];
    int unsigned exp_len[2];
    bit          busy_prev[2];
    bit          abort[2];

    typedef struct {
        logic [15:0] data;
        int unsigned exp_busy;
        int unsigned exp_done;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input int id, input bit v, input int unsigned div);
        for (int unsigned k = 0; k < div; k++) begin
            if (id == 0) qa.push_back(v);
            else         qb.push_back(v);
        end
    endtask

    // Reference frame generator: start, 8 data bits MSB first, [parity], stop.
    task automatic push_pkt(input int id, input logic [15:0] data, input int nbytes, input int unsigned div);
        logic [7:0] byt;
        for (int b = nbytes - 1; b >= 0; b--) begin
            byt = data[b*8 +: 8];
            push_bits(id, 1'b0, div);
            for (int i = 7; i >= 0; i--) push_bits(id, byt[i], div);
`ifdef UART_TX_PARITY_EN
            push_bits(id, ^byt, div);
`endif
            push_bits(id, 1'b1, div);
        end
    endtask

    task automatic mon_dut(input int id, input logic busy, input logic line, input logic done);
        bit e;
        if (!mon_en) return;
        if (busy === 1'b1) begin
            if (!busy_prev[id]) last_gap[id] = idle_run[id];
            idle_run[id] = 0;
            busy_run[id]++;
            check(id == 0 ? "a_done_while_busy" : "b_done_while_busy", done, 1'b0);
            if ((id == 0 ? qa.size() : qb.size()) == 0) begin
                check(id == 0 ? "a_unexpected_busy" : "b_unexpected_busy", busy, 1'b0);
            end else begin
                e = (id == 0) ? qa.pop_front() : qb.pop_front();
                check(id == 0 ? "a_line" : "b_line", line, e);
            end
        end else begin
            idle_run[id]++;
            check(id == 0 ? "a_idle_line" : "b_idle_line", line, 1'b1);
            if (busy_prev[id]) begin
                if (abort[id]) begin
                    check(id == 0 ? "a_done_after_abort" : "b_done_after_abort", done, 1'b0);
                end else begin
                    check(id == 0 ? "a_busy_len" : "b_busy_len", busy_run[id], exp_len[id]);
                    check(id == 0 ? "a_done_on_fall" : "b_done_on_fall", done, 1'b1);
                end
                abort[id] = 1'b0;
            end else begin
                check(id == 0 ? "a_stray_done" : "b_stray_done", done, 1'b0);
            end
            busy_run[id] = 0;
        end
        if (done === 1'b1) done_cnt[id]++;
        busy_prev[id] = (busy === 1'b1);
    endtask

    task automatic step();
        @(negedge clk);
        mon_dut(0, a_busy, a_line, a_done);
        mon_dut(1, b_busy, b_line, b_done);
    endtask

    task automatic wait_done(input int id, input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (done_cnt[id] < target && n < budget) begin
            step();
            n++;
        end
        check(id == 0 ? "a_done_reached" : "b_done_reached", 32'(done_cnt[id] >= target), 1);
    endtask

    initial begin
        vecs[0] = '{16'h2C4C, LEN_A, 1};
        vecs[1] = '{16'h0000, LEN_A, 1};
        vecs[2] = '{16'hFFFF, LEN_A, 1};
        vecs[3] = '{16'h8001, LEN_A, 1};
        vecs[4] = '{16'hA5A5, LEN_A, 1};
        vecs[5] = '{16'h7E01, LEN_A, 1};
        exp_len[0] = LEN_A;
        exp_len[1] = LEN_B;
        for (int i = 0; i < 2; i++) begin
            busy_run[i] = 0; idle_run[i] = 0; last_gap[i] = 0;
            done_cnt[i] = 0; busy_prev[i] = 1'b0; abort[i] = 1'b0;
        end

        // Reset, with start asserted to show reset takes priority.
        a_rst = 1'b1; a_start = 1'b1; a_storage = 16'h1234;
        b_rst = 1'b1; b_start = 1'b0; b_storage = 8'h00;
        repeat (3) step();
        check("a_rst_line", a_line, 1'b1);
        check("a_rst_busy", a_busy, 1'b0);
        check("a_rst_done", a_done, 1'b0);
        check("b_rst_line", b_line, 1'b1);
        check("b_rst_busy", b_busy, 1'b0);
        check("b_rst_done", b_done, 1'b0);
        a_rst = 1'b0; a_start = 1'b0; b_rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) step();

        // Table: single packets on the CLK_DIV=4, BYTES=2 instance.
        for (int v = 0; v < 6; v++) begin
            done_cnt[0] = 0;
            exp_len[0]  = vecs[v].exp_busy;
            push_pkt(0, vecs[v].data, 2, 4);
            a_storage = vecs[v].data;
            a_start   = 1'b1;
            step();
            check("a_accept_busy", a_busy, 1'b1);
            check("a_accept_line", a_line, 1'b0);
            a_start   = 1'b0;
            a_storage = 16'($urandom);
            wait_done(0, 1, 200);
            repeat (5) step();
            check("vec_done_cnt", done_cnt[0], vecs[v].exp_done);
            check("vec_queue_empty", qa.size(), 0);
        end

        // Start while busy is ignored and not queued.
        done_cnt[0] = 0;
        push_pkt(0, 16'h2C4C, 2, 4);
        a_storage = 16'h2C4C; a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (19) step();
        a_storage = 16'hFFFF; a_start = 1'b1;
        step();
        a_start = 1'b0;
        wait_done(0, 1, 200);
        repeat (120) step();
        check("busy_start_done_cnt", done_cnt[0], 1);
        check("busy_start_queue", qa.size(), 0);

        // Held start: two back-to-back packets, one idle (done) cycle between.
        done_cnt[0] = 0;
        push_pkt(0, 16'hA5A5, 2, 4);
        push_pkt(0, 16'hA5A5, 2, 4);
        a_storage = 16'hA5A5; a_start = 1'b1;
        step();
        wait_done(0, 1, 200);
        step();
        check("held_restart_busy", a_busy, 1'b1);
        check("held_restart_line", a_line, 1'b0);
        check("held_gap", last_gap[0], 1);
        a_start = 1'b0;
        wait_done(0, 2, 200);
        repeat (100) step();
        check("held_done_cnt", done_cnt[0], 2);
        check("held_queue", qa.size(), 0);

        // Reset during DATA of byte 0 discards the packet without done.
        done_cnt[0] = 0;
        push_pkt(0, 16'h2C4C, 2, 4);
        a_storage = 16'h2C4C; a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (11) step();
        check("pre_rst_busy", a_busy, 1'b1);
        a_rst = 1'b1; abort[0] = 1'b1;
        step();
        check("rst_mid_busy", a_busy, 1'b0);
        check("rst_mid_line", a_line, 1'b1);
        check("rst_mid_done", a_done, 1'b0);
        a_rst = 1'b0;
        qa.delete();
        repeat (100) step();
        check("rst_mid_no_done", done_cnt[0], 0);
        push_pkt(0, 16'h2C4C, 2, 4);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        wait_done(0, 1, 200);
        repeat (5) step();
        check("after_rst_done_cnt", done_cnt[0], 1);
        check("after_rst_queue", qa.size(), 0);

        // Edge divider on the CLK_DIV=2, BYTES=1 instance.
        for (int v = 0; v < 2; v++) begin
            done_cnt[1] = 0;
            b_storage = (v == 0) ? 8'h00 : 8'hFF;
            push_pkt(1, {8'h00, b_storage}, 1, 2);
            b_start = 1'b1;
            step();
            b_start = 1'b0;
            wait_done(1, 1, 100);
            repeat (5) step();
            check("b_done_cnt", done_cnt[1], 1);
            check("b_queue_empty", qb.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_packet_tx.md
# uart_packet_tx

Serial transmitter that sends a multi-byte word as a packet of back-to-back UART frames: the transmit end of the controller's serial link. It is used by bench and loopback logic to drive the `uart_data` line of the receiver. It can also act as the status/telemetry uplink from the controller. It loads a `STORAGE_MAX`-wide word on a start strobe, shifts it out byte by byte at a fixed clocks-per-bit rate, and reports busy/done.

## Interface
- `CLK_DIV`, 16: clock cycles per serial bit; legal range 2..65535.
- `BYTES`, 2: bytes per packet; `STORAGE_MAX` = 8*`BYTES`.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request to send `storage`; sampled only while idle.
- `storage`  input  `STORAGE_MAX`  packet payload; captured on accepted `start`.
- `uart_data`  output  1  serial line; idle high.
- `busy`  output  1  high while a packet is in flight.
- `done`  output  1  one-cycle pulse after the last stop bit completes.

## Operation
- Frame format: start bit (0), 8 data bits MSB first, optional parity, stop bit (1).
- Packet byte order: most significant byte (`storage[STORAGE_MAX-1 -: 8]`) first. There is no idle gap between frames.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `uart_data`=1 and `busy`=0. When `start`=1, latch `storage` into the shift register, clear the byte counter, go to START, and set `busy`=1.
- START: drive 0 for `CLK_DIV` cycles, then go to DATA with the bit counter at 7.
- DATA: drive the current MSB for `CLK_DIV` cycles and shift left by one. After bit 0, go to PARITY or STOP.
- STOP: drive 1 for `CLK_DIV` cycles.
  - If the byte counter is `BYTES`-1: go to IDLE and pulse `done`.
  - Otherwise: increment the byte counter and go to START.
- `start` while `busy`=1 is ignored and is not queued. Changes to `storage` after acceptance have no effect.
- `start` held high continuously: a new packet is accepted on the first IDLE cycle after `done`.
- Reset values: `uart_data`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- `rst` mid-packet: the next cycle shows `uart_data`=1 and `busy`=0; no `done` is pulsed and the partial packet is discarded.
- Counters: the bit-period counter is $clog2(`CLK_DIV`) bits wide and wraps from `CLK_DIV`-1 to 0. The bit counter is 3 bits. The byte counter is $clog2(`BYTES`) bits wide, minimum 1.

## Timing
- Accept: `start` sampled high in IDLE on cycle N. `uart_data` falls and `busy` rises at cycle N+1.
- Each bit is held for exactly `CLK_DIV` cycles, and all bit edges are aligned to the period counter wrap.
- Frame length F = 10*`CLK_DIV` cycles, or 11*`CLK_DIV` with parity.
- Packet length: `busy` is high for exactly `BYTES`*F cycles.
- `done` is high on the cycle `busy` falls, for one cycle. The earliest next accept is that same cycle if `start`=1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is inserted after DATA and drives the even parity bit (XOR of the 8 data bits) for `CLK_DIV` cycles. F becomes 11*`CLK_DIV`.
- Not defined: there is no PARITY state, F = 10*`CLK_DIV`, and the framing matches the current receiver.

## Structure
- Shared package `uart_pkg` contains:
  - the state enum `tx_state_t`;
  - `UART_DATA_BITS`=8, `UART_START_BIT`=1'b0, `UART_STOP_BIT`=1'b1, `UART_IDLE`=1'b1;
  - the `STORAGE_MAX` computation. The receiver uses the same package.
- One sub-module, `baud_tick`: a `CLK_DIV` period counter with a synchronous clear, emitting a one-cycle `tick` at the end of each bit period. The FSM stays in the top module.

## Test plan
- Basic packet: `CLK_DIV`=4, `BYTES`=2, `storage`=16'h2C4C, `start` pulse.
  - `uart_data` bits are 0_00101100_1_0_01001100_1, each held 4 cycles.
  - `busy` is high for 80 cycles, followed by a single `done` pulse.
- Start while busy: pulse `start` with 16'hFFFF at cycle 20 of a 16'h2C4C packet.
  - The line is unchanged, no second packet is sent, and there is exactly one `done`.
- Held `start`: `start` held high with 16'hA5A5.
  - Two packets go out back-to-back, with the second START beginning the cycle after `done`.
  - Each packet has `busy`=80 cycles.
- Reset mid-frame: assert `rst` for 1 cycle during DATA of byte 0.
  - Next cycle `uart_data`=1, `busy`=0, and `done` never pulses.
  - A new `start` then sends a correct full packet.
- Parity (`UART_TX_PARITY_EN`): `storage`=16'h2C4C.
  - The parity bits are 1 for 8'h2C and 1 for 8'h4C.
  - Frames are 44 cycles each and `busy`=88 cycles.
- Edge divider: `CLK_DIV`=2, `BYTES`=1, `storage`=8'h00 then 8'hFF.
  - Expected lines: 0_00000000_1 and 0_11111111_1, each bit held 2 cycles, 20 cycles per packet.
